// File: rtl/cu_issue_if.sv
// Instruction handshake between the program sequencer and the CU issue stage.
interface cu_issue_if #(
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                   instr_valid;
  logic [INSTR_WIDTH-1:0] instr;
  logic                   instr_ready;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/cu_issue_ctrl.sv
// CU issue stage: decodes instruction words into E/W-stage ps_* control buses,
// applies a one-bubble RAW interlock and accumulates per-unit sticky flags into astat.
module cu_issue_ctrl #(
  parameter int unsigned INSTR_WIDTH   = 32,
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned SIGNAL_WIDTH  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  cu_issue_if.slave                in_if,
  output logic                     ps_alu_en,
  output logic                     ps_alu_log,
  output logic                     ps_alu_sat,
  output logic [1:0]               ps_alu_hc,
  output logic [2:0]               ps_alu_sc,
  output logic                     ps_mul_en,
  output logic                     ps_mul_otreg,
  output logic [3:0]               ps_mul_dtsts,
  output logic [1:0]               ps_mul_cls,
  output logic [1:0]               ps_mul_sc,
  output logic                     ps_shf_en,
  output logic [1:0]               ps_shf_cls,
  output logic [ADDRESS_WIDTH-1:0] ps_xb_raddx,
  output logic [ADDRESS_WIDTH-1:0] ps_xb_raddy,
  output logic [ADDRESS_WIDTH-1:0] ps_xb_wadd,
  output logic [SIGNAL_WIDTH-1:0]  ps_xb_w_cuEn,
  output logic                     ps_xb_w_bcEn,
  input  logic                     alu_ps_az,
  input  logic                     alu_ps_an,
  input  logic                     alu_ps_ac,
  input  logic                     alu_ps_av,
  input  logic                     mul_ps_mv,
  input  logic                     mul_ps_mn,
  input  logic                     shf_ps_sv,
  input  logic                     shf_ps_sz,
  output logic [7:0]               astat,
  output logic                     illegal_op
);

  localparam logic [1:0] UNIT_ALU = 2'b01;
  localparam logic [1:0] UNIT_MUL = 2'b10;
  localparam logic [1:0] UNIT_SHF = 2'b11;
  localparam logic [2:0] MISC_NOP = 3'b000;
  localparam logic [2:0] MISC_BCW = 3'b001;

  typedef struct packed {
    logic                     alu_en;
    logic                     alu_log;
    logic                     alu_sat;
    logic [1:0]               alu_hc;
    logic [2:0]               alu_sc;
    logic                     mul_en;
    logic                     mul_otreg;
    logic [3:0]               mul_dtsts;
    logic [1:0]               mul_cls;
    logic [1:0]               mul_sc;
    logic                     shf_en;
    logic [1:0]               shf_cls;
    logic [ADDRESS_WIDTH-1:0] raddx;
    logic [ADDRESS_WIDTH-1:0] raddy;
    logic [ADDRESS_WIDTH-1:0] rn;
    logic [2:0]               wr_cu;
    logic                     bc_wr;
    logic                     illegal;
  } e_stage_t;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] wadd;
    logic [2:0]               cu_en;
    logic                     bc_en;
    logic                     illegal;
    logic                     upd_alu;
    logic                     upd_mul;
    logic                     upd_shf;
  } w_stage_t;

  e_stage_t e_q, e_d;
  w_stage_t w_q, w_d;
  logic [7:0] astat_q, astat_d;
  logic       rdy_en_q, rdy_en_d;

  logic [INSTR_WIDTH-1:0]   instr_w;
  logic [1:0]               unit;
  logic [ADDRESS_WIDTH-1:0] f_rn, f_rx, f_ry;
  logic                     e_writes, hazard, accept;
  logic                     unused_rsvd;

  assign instr_w     = in_if.instr;
  assign unit        = instr_w[31:30];
  assign f_rn        = ADDRESS_WIDTH'(instr_w[11:8]);
  assign f_rx        = ADDRESS_WIDTH'(instr_w[7:4]);
  assign f_ry        = ADDRESS_WIDTH'(instr_w[3:0]);
  assign unused_rsvd = ^instr_w[18:12];

  // RAW interlock: MISC ops carry no source operands.
  assign e_writes = (|e_q.wr_cu) | e_q.bc_wr;
  assign hazard   = in_if.instr_valid && (unit != 2'b00) && e_writes &&
                    ((f_rx == e_q.rn) || (f_ry == e_q.rn));
  assign in_if.instr_ready = rdy_en_q & ~hazard;
  assign accept   = in_if.instr_valid & in_if.instr_ready;
  assign rdy_en_d = 1'b1;

  // Decode into the E register; a non-accepted cycle becomes a bubble.
  always_comb begin
    e_d = '0;
    if (accept) begin
      e_d.rn = f_rn;
      case (unit)
        UNIT_ALU: begin
          e_d.alu_en  = 1'b1;
          e_d.alu_sc  = instr_w[29:27];
          e_d.alu_hc  = instr_w[26:25];
          e_d.alu_log = instr_w[24];
          e_d.alu_sat = instr_w[23];
          e_d.raddx   = f_rx;
          e_d.raddy   = f_ry;
          e_d.wr_cu   = 3'b001;
        end
        UNIT_MUL: begin
          e_d.mul_en    = 1'b1;
          e_d.mul_sc    = instr_w[28:27];
          e_d.mul_cls   = instr_w[26:25];
          e_d.mul_otreg = instr_w[24];
          e_d.mul_dtsts = instr_w[22:19];
          e_d.raddx     = f_rx;
          e_d.raddy     = f_ry;
          e_d.wr_cu     = instr_w[24] ? 3'b000 : 3'b010;
        end
        UNIT_SHF: begin
          e_d.shf_en  = 1'b1;
          e_d.shf_cls = instr_w[28:27];
          e_d.raddx   = f_rx;
          e_d.raddy   = f_ry;
          e_d.wr_cu   = 3'b100;
        end
        default: begin
          if (instr_w[29:27] == MISC_BCW) e_d.bc_wr = 1'b1;
          else if (instr_w[29:27] != MISC_NOP) e_d.illegal = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    w_d         = '0;
    w_d.wadd    = e_q.rn;
    w_d.cu_en   = e_q.wr_cu;
    w_d.bc_en   = e_q.bc_wr;
    w_d.illegal = e_q.illegal;
    w_d.upd_alu = e_q.alu_en;
    w_d.upd_mul = e_q.mul_en;
    w_d.upd_shf = e_q.shf_en;
  end

  // Flags of the unit in W are captured at the end of that cycle.
  always_comb begin
    astat_d = astat_q;
    if (w_q.upd_alu) astat_d[3:0] = {alu_ps_av, alu_ps_ac, alu_ps_an, alu_ps_az};
    if (w_q.upd_mul) astat_d[5:4] = {mul_ps_mn, mul_ps_mv};
    if (w_q.upd_shf) astat_d[7:6] = {shf_ps_sz, shf_ps_sv};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q      <= '0;
      w_q      <= '0;
      astat_q  <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      e_q      <= e_d;
      w_q      <= w_d;
      astat_q  <= astat_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  assign ps_alu_en    = e_q.alu_en;
  assign ps_alu_log   = e_q.alu_log;
  assign ps_alu_sat   = e_q.alu_sat;
  assign ps_alu_hc    = e_q.alu_hc;
  assign ps_alu_sc    = e_q.alu_sc;
  assign ps_mul_en    = e_q.mul_en;
  assign ps_mul_otreg = e_q.mul_otreg;
  assign ps_mul_dtsts = e_q.mul_dtsts;
  assign ps_mul_cls   = e_q.mul_cls;
  assign ps_mul_sc    = e_q.mul_sc;
  assign ps_shf_en    = e_q.shf_en;
  assign ps_shf_cls   = e_q.shf_cls;
  assign ps_xb_raddx  = e_q.raddx;
  assign ps_xb_raddy  = e_q.raddy;
  assign ps_xb_wadd   = w_q.wadd;
  assign ps_xb_w_cuEn = SIGNAL_WIDTH'(w_q.cu_en);
  assign ps_xb_w_bcEn = w_q.bc_en;
  assign illegal_op   = w_q.illegal;
  assign astat        = astat_q;

endmodule

// File: doc/cu_issue_ctrl.md
Name: cu_issue_ctrl

Overview:
- Program-sequencer-side issue stage that sits directly upstream of the compute unit.
- Accepts compute instruction words over a valid/ready handshake and decodes them into the registered ps_* control buses (ALU, multiplier, shifter, crossbar/RF addresses and write enables).
- Runs a two-stage E/W pipeline with a one-bubble RAW interlock.
- Collects the unit flags returned by the compute unit into a sticky-per-unit ASTAT register.

Parameters:
INSTR_WIDTH, 32, instruction word width (field layout below is fixed for 32)
ADDRESS_WIDTH, 4, RF register address width
SIGNAL_WIDTH, 3, crossbar CU write-source select width (>=3)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
instr_valid  in  1  instruction word present
instr  in  INSTR_WIDTH  instruction word
instr_ready  out  1  instruction accepted on the clk edge where valid&ready
ps_alu_en, ps_alu_log, ps_alu_sat  out  1 each  ALU controls
ps_alu_hc  out  2  ALU control
ps_alu_sc  out  3  ALU control
ps_mul_en, ps_mul_otreg  out  1 each  multiplier controls
ps_mul_dtsts  out  4  multiplier control
ps_mul_cls, ps_mul_sc  out  2 each  multiplier controls
ps_shf_en  out  1  shifter enable
ps_shf_cls  out  2  shifter class
ps_xb_raddx, ps_xb_raddy  out  ADDRESS_WIDTH each  read addresses (E stage)
ps_xb_wadd  out  ADDRESS_WIDTH  write address (W stage)
ps_xb_w_cuEn  out  SIGNAL_WIDTH  one-hot CU write source: bit0 ALU, bit1 MUL, bit2 SHF (W stage)
ps_xb_w_bcEn  out  1  bus-connect write (W stage)
alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av  in  1 each  ALU flags
mul_ps_mv, mul_ps_mn  in  1 each  multiplier flags
shf_ps_sv, shf_ps_sz  in  1 each  shifter flags
astat  out  8  {sz,sv,mn,mv,av,ac,an,az}
illegal_op  out  1  one-cycle pulse in the W cycle of an undefined instruction

Behaviour:
- Instruction fields:
  - [31:30] unit: 00 MISC, 01 ALU, 10 MUL, 11 SHF
  - [29:27] ALU sc. [28:27] MUL sc / SHF cls.
  - [26:25] ALU hc / MUL cls
  - [24] ALU log / MUL otreg
  - [23] ALU sat
  - [22:19] MUL dtsts
  - [18:12] reserved
  - [11:8] rn (destination), [7:4] rx, [3:0] ry
- MISC sub-op in [29:27]: 000 NOP, 001 BCW (write bc_dt to rn). All other values are illegal and execute as NOP.
- E stage (cycle after acceptance):
  - Unit enable asserted for exactly one cycle.
  - Unit control fields, raddx=rx and raddy=ry driven from the E register.
  - MISC/NOP drives all enables 0.
- W stage (the cycle following E):
  - wadd=rn.
  - cuEn one-hot per unit, or bcEn for BCW.
  - No RF write for NOP, illegal, or MUL with otreg=1 (result goes to the MR register).
- Throughput: 1 instruction/cycle. Total latency is acceptance edge -> RF write at end of W (2 cycles).
- Interlock:
  - instr_ready=0 when the incoming instruction reads rx or ry equal to the rn of a valid, RF-writing E-stage instruction. Applies to all units; for MISC, rx/ry are ignored.
  - This inserts exactly one bubble (E empty, all enables 0).
  - Otherwise instr_ready=1.
  - Write-after-write needs no stall.
- Flags: at the end of each W cycle the executing unit's flags are sampled into astat. Only that unit's bits change:
  - ALU updates az/an/ac/av.
  - MUL updates mv/mn.
  - SHF updates sz/sv.
  - NOP/BCW/illegal leave astat unchanged.
- Reset (asynchronous, reset=0):
  - E and W registers are invalidated and every output is cleared to 0, including astat, illegal_op and all enables.
  - instr_ready=0 while reset is asserted and 1 from the first edge after release.
  - An in-flight instruction is discarded with no RF write.
- Simultaneous events:
  - Acceptance and W writeback happen in the same cycle independently.
  - A stall does not block W from draining.

Test Plan:
- ALU add (unit 01, sc=000, rn=3, rx=1, ry=2) with valid=1 -> cycle+1: ps_alu_en=1, raddx=1, raddy=2. Cycle+2: cuEn=001, wadd=3, astat ALU bits=flags input, mul/shf bits unchanged.
- Back-to-back ALU rn=5 then SHF reading rx=5 -> instr_ready=0 for one cycle, one bubble (all enables 0). SHF E stage follows; shf_en=1, raddx=5.
- MUL otreg=1, dtsts=1010, cls=01 -> ps_mul_en=1 with fields matching. W stage: cuEn=000, bcEn=0. astat mv/mn updated.
- BCW rn=7 -> W: bcEn=1, wadd=7, cuEn=000. MISC sub-op 101 -> illegal_op=1 for one W cycle, no writes, astat unchanged.
- Stream of 8 independent instructions with valid held 1 -> instr_ready stays 1 and one enable pulse issues per cycle.
- Assert reset low mid-stream with E and W both occupied -> all outputs 0 immediately (asynchronously) and no RF write. After release, the first accepted instruction issues normally.
